// File: rtl/serial_sub_pkg.sv
// Shared types and sizing for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned CNT_W         = $clog2(DEFAULT_WIDTH);

  // Bit-counter width for an arbitrary operand width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor4_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor4.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor4_if #(
  parameter int unsigned WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bo;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
`ifdef SUB_OVF_EN
    input  ovf,
`endif
    input  busy, done, d, bo
  );

  modport slave (
    input  start, a, b, bin,
`ifdef SUB_OVF_EN
    output ovf,
`endif
    output busy, done, d, bo
  );

endinterface

// File: rtl/full_subtractor1.sv
// Combinational 1-bit full subtractor: d = x - y - bi.
module full_subtractor1 (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bi,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_x ^ i_y ^ i_bi;
  assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_bi);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial subtractor, LSB first, one bit per cycle with a registered borrow.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module serial_subtractor4
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_subtractor4_if.slave    bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] r_d;
  logic             r_br;
  logic             r_bo;
  logic [CntW-1:0]  r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_fs_d;
  logic             w_fs_bo;
  logic [WIDTH-1:0] w_diff_nxt;
`ifdef SUB_OVF_EN
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_ovf;
`endif

  full_subtractor1 u_fs (
    .i_x  (r_a[0]),
    .i_y  (r_b[0]),
    .i_bi (r_br),
    .o_d  (w_fs_d),
    .o_bo (w_fs_bo)
  );

  assign w_diff_nxt = {w_fs_d, r_diff[WIDTH-1:1]};
  assign w_last     = (r_cnt == CntW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        if (w_last) w_state_nxt = StDone;
      end
      StDone: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = StRun;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_d     <= '0;
      r_br    <= 1'b0;
      r_bo    <= 1'b0;
      r_cnt   <= '0;
`ifdef SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_br  <= bus.bin;
        r_cnt <= '0;
`ifdef SUB_OVF_EN
        // MSBs are shifted away during RUN, so keep them for the overflow test.
        r_a_msb <= bus.a[WIDTH-1];
        r_b_msb <= bus.b[WIDTH-1];
`endif
      end else if (r_state == StRun) begin
        r_a    <= r_a >> 1;
        r_b    <= r_b >> 1;
        r_br   <= w_fs_bo;
        r_diff <= w_diff_nxt;
        r_cnt  <= r_cnt + CntW'(1);
        if (w_last) begin
          r_d  <= w_diff_nxt;
          r_bo <= w_fs_bo;
`ifdef SUB_OVF_EN
          r_ovf <= (r_a_msb != r_b_msb) & (w_fs_d != r_a_msb);
`endif
        end
      end
    end
  end

  assign bus.busy = (r_state == StRun);
  assign bus.done = (r_state == StDone);
  assign bus.d    = r_d;
  assign bus.bo   = r_bo;
`ifdef SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule
